// File: rtl/mrsc_decoder.sv
// rtl/mrsc_decoder.sv - two-stage MRSC codeword decoder with valid/ready flow and saturating error counters
module mrsc_decoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      encoded_word,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_word,
  output logic             err_corrected,
  output logic             err_uncorrectable,
  input  logic             clear_counts,
  output logic [CNT_W-1:0] corrected_count,
  output logic [CNT_W-1:0] uncorrectable_count
);

  function automatic logic [7:0] calc_h(input logic [15:0] d);
    logic [7:0] h;
    h = '0;
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 2; k++)
        h[2*r+k] = d[4*r+2*k] ^ d[4*r+2*k+1];
    return h;
  endfunction

  function automatic logic [7:0] calc_v(input logic [15:0] d);
    logic [7:0] v;
    v = '0;
    for (int c = 0; c < 4; c++)
      for (int k = 0; k < 2; k++)
        v[2*c+k] = d[c+8*k] ^ d[c+4+8*k];
    return v;
  endfunction

  logic             r_s1_valid;
  logic [15:0]      r_s1_d;
  logic [7:0]       r_s1_h;
  logic [7:0]       r_s1_v;
  logic [7:0]       r_s1_sh;
  logic [7:0]       r_s1_sv;
  logic             r_out_valid;
  logic [15:0]      r_out_word;
  logic             r_corr;
  logic             r_unc;
  logic [CNT_W-1:0] r_ccnt;
  logic [CNT_W-1:0] r_ucnt;

  logic        w_adv1;
  logic        w_adv2;
  logic        w_in_hs;
  logic        w_out_hs;
  logic [15:0] w_d;
  logic [7:0]  w_h;
  logic [7:0]  w_v;
  logic [15:0] w_mask;
  logic [15:0] w_fixed;
  logic [4:0]  w_syn_cnt;
  logic [15:0] w_residual;
  logic        w_corr;
  logic        w_unc;

  assign w_d = encoded_word[15:0];
  assign w_h = encoded_word[23:16];
  assign w_v = encoded_word[31:24];

  assign w_adv2   = !r_out_valid || out_ready;
  assign w_adv1   = !r_s1_valid || w_adv2;
  assign in_ready = w_adv1 && !rst;
  assign w_in_hs  = in_valid && in_ready;
  assign w_out_hs = r_out_valid && out_ready;

  // A data bit is flipped only where its row-pair and column-pair syndromes both fire
  always_comb begin
    w_mask = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        w_mask[4*r+c] = r_s1_sh[2*r + c/2] & r_s1_sv[2*c + r/2];
  end

  assign w_fixed    = r_s1_d ^ w_mask;
  assign w_syn_cnt  = 5'($countones(r_s1_sh)) + 5'($countones(r_s1_sv));
  assign w_residual = {calc_h(w_fixed) ^ r_s1_h, calc_v(w_fixed) ^ r_s1_v};
  assign w_corr     = ((w_mask != 16'd0) && (w_residual == 16'd0)) ||
                      ((w_mask == 16'd0) && (w_syn_cnt == 5'd1));
  assign w_unc      = (w_syn_cnt != 5'd0) && !w_corr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_d     <= '0;
      r_s1_h     <= '0;
      r_s1_v     <= '0;
      r_s1_sh    <= '0;
      r_s1_sv    <= '0;
    end else if (w_adv1) begin
      r_s1_valid <= w_in_hs;
      if (w_in_hs) begin
        r_s1_d  <= w_d;
        r_s1_h  <= w_h;
        r_s1_v  <= w_v;
        r_s1_sh <= calc_h(w_d) ^ w_h;
        r_s1_sv <= calc_v(w_d) ^ w_v;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_word  <= '0;
      r_corr      <= 1'b0;
      r_unc       <= 1'b0;
    end else if (w_adv2) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_word <= w_fixed;
        r_corr     <= w_corr;
        r_unc      <= w_unc;
      end
    end
  end

  // Clear takes priority over any increment on the same edge
  always_ff @(posedge clk) begin
    if (rst || clear_counts) begin
      r_ccnt <= '0;
      r_ucnt <= '0;
    end else begin
      if (w_out_hs && r_corr && !(&r_ccnt))
        r_ccnt <= r_ccnt + 1'b1;
      if (w_out_hs && r_unc && !(&r_ucnt))
        r_ucnt <= r_ucnt + 1'b1;
    end
  end

  assign out_valid           = r_out_valid;
  assign out_word            = r_out_word;
  assign err_corrected       = r_corr;
  assign err_uncorrectable   = r_unc;
  assign corrected_count     = r_ccnt;
  assign uncorrectable_count = r_ucnt;

endmodule

// File: tb/tb_mrsc_decoder.sv
// tb/tb_mrsc_decoder.sv - scoreboard bench for mrsc_decoder
module tb_mrsc_decoder;

  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   encoded_word = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [15:0]   out_word;
  logic          err_corrected;
  logic          err_uncorrectable;
  logic          clear_counts = 1'b0;
  logic [CW-1:0] corrected_count;
  logic [CW-1:0] uncorrectable_count;

  int checks = 0;
  int errors = 0;

  logic [17:0] exp_q[$];
  int          occ = 0;
  bit          started = 0;
  bit          bp_en = 0;
  logic [CW-1:0] m_ccnt = '0;
  logic [CW-1:0] m_ucnt = '0;
  bit          prev_stall = 0;
  logic [17:0] prev_out = '0;

  mrsc_decoder #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .encoded_word(encoded_word),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
    .err_corrected(err_corrected), .err_uncorrectable(err_uncorrectable),
    .clear_counts(clear_counts),
    .corrected_count(corrected_count), .uncorrectable_count(uncorrectable_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc(input logic [15:0] d);
    logic [7:0] h;
    logic [7:0] v;
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 2; k++)
        h[2*r+k] = d[4*r+2*k] ^ d[4*r+2*k+1];
    for (int c = 0; c < 4; c++)
      for (int k = 0; k < 2; k++)
        v[2*c+k] = d[c+8*k] ^ d[c+4+8*k];
    return {v, h, d};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  always @(posedge clk) begin
    #2;
    if (bp_en) out_ready = 1'($urandom_range(0, 1));
  end

  // Monitor: scoreboard pop, counter model, stall stability and in_ready rule
  always @(negedge clk) begin
    logic [17:0] e;
    if (rst) begin
      exp_q.delete();
      occ = 0;
      m_ccnt = '0;
      m_ucnt = '0;
      prev_stall = 0;
      started = 1;
    end else if (started) begin
      check("corrected_count", 32'(corrected_count), 32'(m_ccnt));
      check("uncorrectable_count", 32'(uncorrectable_count), 32'(m_ucnt));
      check("in_ready_rule", 32'(in_ready), 32'((occ < 2) || out_ready));
      if (prev_stall)
        check("stall_hold", {13'd0, out_valid, err_uncorrectable, err_corrected, out_word},
              {13'd0, 1'b1, prev_out[17], prev_out[16], prev_out[15:0]});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_output", {15'd0, out_valid, out_word}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("out_word", 32'(out_word), 32'(e[15:0]));
          check("flags", {30'd0, err_uncorrectable, err_corrected}, {30'd0, e[17], e[16]});
          if (e[16] && !(&m_ccnt)) m_ccnt = m_ccnt + 1'b1;
          if (e[17] && !(&m_ucnt)) m_ucnt = m_ucnt + 1'b1;
        end
        occ--;
      end
      if (clear_counts) begin
        m_ccnt = '0;
        m_ucnt = '0;
      end
      if (in_valid && in_ready) occ++;
      prev_stall = out_valid && !out_ready;
      prev_out   = {err_uncorrectable, err_corrected, out_word};
    end
  end

  task automatic send(input logic [31:0] cw, input logic [15:0] w, input logic c, input logic u);
    bit acc = 0;
    in_valid = 1'b1;
    encoded_word = cw;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      acc = in_ready;
      if (acc) exp_q.push_back({u, c, w});
      @(posedge clk);
      #1;
      if (acc) break;
    end
    if (!acc) check("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk);
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    #1;
  endtask

  task automatic check_reset_state();
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_word", 32'(out_word), 32'd0);
    check("rst_flags", {30'd0, err_uncorrectable, err_corrected}, 32'd0);
    check("rst_counts", {corrected_count, uncorrectable_count}, 32'd0);
  endtask

  initial begin
    logic [15:0] d;
    logic [31:0] cw;
    bit          ok;
    repeat (3) @(posedge clk);
    check_reset_state();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 out_ready = 1'b1;

    send(32'h918380FA, 16'h80FA, 1'b0, 1'b0);
    send(32'h918380DA, 16'h80FA, 1'b1, 1'b0);
    send(32'h918280FA, 16'h80FA, 1'b1, 1'b0);
    send(32'h918380F9, 16'h80F9, 1'b0, 1'b1);
    send(32'h908380FA, 16'h80FA, 1'b1, 1'b0);
    send(32'h918300FA, 16'h80FA, 1'b1, 1'b0);
    send(32'h938280FA, 16'h80FA, 1'b0, 1'b1);
    drain();
    @(negedge clk);
    check("dir_ccnt_sat", 32'(corrected_count), 32'd3);
    check("dir_ucnt", 32'(uncorrectable_count), 32'd2);

    @(posedge clk);
    #1 clear_counts = 1'b1;
    @(posedge clk);
    #1 clear_counts = 1'b0;
    @(negedge clk);
    check("clear_ccnt", 32'(corrected_count), 32'd0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) send(32'h918380DA, 16'h80FA, 1'b1, 1'b0);
    drain();
    @(negedge clk);
    check("sat_ccnt", 32'(corrected_count), 32'd3);

    @(posedge clk);
    #1 out_ready = 1'b0;
    send(32'h918380DA, 16'h80FA, 1'b1, 1'b0);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin ok = 1; break; end
    end
    check("wait_out_valid", 32'(ok), 32'd1);
    out_ready = 1'b1;
    clear_counts = 1'b1;
    @(posedge clk);
    #1 clear_counts = 1'b0;
    @(negedge clk);
    check("clear_wins", 32'(corrected_count), 32'd0);
    @(posedge clk);
    #1;

    bp_en = 1;
    for (int i = 0; i < 8; i++) begin
      d  = 16'($urandom);
      cw = enc(d);
      if (i % 2 == 1) begin
        cw[(i*3) % 16] = ~cw[(i*3) % 16];
        send(cw, d, 1'b1, 1'b0);
      end else begin
        send(cw, d, 1'b0, 1'b0);
      end
    end
    drain();
    bp_en = 0;
    out_ready = 1'b1;

    @(posedge clk);
    #1 out_ready = 1'b0;
    send(32'h918380FA, 16'h80FA, 1'b0, 1'b0);
    send(32'h918380DA, 16'h80FA, 1'b1, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    check_reset_state();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_no_stale", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1 out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    send(32'h918380FA, 16'h80FA, 1'b0, 1'b0);
    drain();
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
